// File: rtl/sdram_model.sv
// sdram_model: behavioural SDRAM back-end for cache_top line fills and write-backs.
// An access has a programmable latency and ends with a one-cycle rdy pulse.
// After reset the array is filled with a known pattern: word i = byte (i mod 256) replicated.
// Optional periodic refresh stalls are enabled by defining SDRAM_REFRESH_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | rewrite the array with its pattern, one word per cycle
// IDLE  | accept an access strobe
// WAIT  | count down the access latency
// ACK   | access complete, rdy high for this one cycle
// REFR  | refresh stall (only when SDRAM_REFRESH_EN is defined)
module sdram_model #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Address,
  input  logic              wr_rd,
  input  logic              mstrb,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] DOut,
  output logic              rdy,
  output logic              busy,
  output logic              ovr,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WAIT    = 3'd2,
`ifdef SDRAM_REFRESH_EN
    S_ACK     = 3'd3,
    S_REFRESH = 3'd4
`else
    S_ACK     = 3'd3
`endif
  } state_e;

  // LATENCY=1 bypasses WAIT; otherwise WAIT holds for LATENCY-1 cycles
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 2);

  state_e                  state_q;
  logic [ADDR_W-1:0]       init_idx_q;
  logic [3:0]              cnt_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [DATA_W-1:0]       din_q;
  logic                    wr_q;
  logic [DATA_W-1:0]       dout_q;
  logic                    rdy_q;
  logic                    ovr_q;
  logic                    ref_due_q;

  logic [DATA_W-1:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0]       addr_idx;
  logic [7:0]              init_byte;
  logic                    ack_from_idle;
  logic                    ack_from_wait;
  logic                    acc_go;
  logic [ADDR_W-1:0]       acc_idx;
  logic [DATA_W-1:0]       acc_din;
  logic                    acc_wr;
  logic                    unused_addr;

  // Upper address bits alias onto the same word
  assign addr_idx    = Address[ADDR_W-1:0];
  assign unused_addr = ^Address[31:ADDR_W];
  assign init_byte   = 8'(init_idx_q);

  // The edge entering ACK commits the access; with LATENCY=1 that is the strobe edge itself
  assign ack_from_idle = (state_q == S_IDLE) && mstrb && (LATENCY == 1);
  assign ack_from_wait = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign acc_go        = ack_from_idle || ack_from_wait;
  assign acc_idx       = ack_from_idle ? addr_idx : idx_q;
  assign acc_din       = ack_from_idle ? din      : din_q;
  assign acc_wr        = ack_from_idle ? wr_rd    : wr_q;

  // Array writes: pattern fill during INIT, access writes on the edge entering ACK
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[init_idx_q] <= {(DATA_W/8){init_byte}};
    end else if (acc_go && acc_wr) begin
      mem[acc_idx] <= acc_din;
    end
  end

`ifdef SDRAM_REFRESH_EN
  localparam logic [15:0] REF_LAST = 16'(REFRESH_PERIOD - 1);
  localparam logic [3:0]  REF_LOAD = 4'(REFRESH_CYCLES - 1);
  logic [15:0] ref_cnt_q;

  // Free-running refresh timer, started when INIT finishes; a pending refresh waits for a strobe-free IDLE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
      ref_due_q <= 1'b0;
    end else if (state_q != S_INIT) begin
      if (state_q == S_IDLE && ref_due_q && !mstrb) ref_due_q <= 1'b0;
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_q <= '0;
        ref_due_q <= 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 16'd1;
      end
    end
  end
`else
  localparam int unused_refresh = REFRESH_PERIOD + REFRESH_CYCLES;
  assign ref_due_q = 1'b0;
`endif

  // Main sequencer: init sweep, access capture, latency countdown, completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (mstrb && state_q != S_IDLE) ovr_q <= 1'b1;
      if (acc_go && !acc_wr) dout_q <= mem[acc_idx];
      case (state_q)
        S_INIT: begin
          if (init_idx_q == '1) state_q <= S_IDLE;
          else                  init_idx_q <= init_idx_q + 1'b1;
        end
        S_IDLE: begin
          if (mstrb) begin
            idx_q <= addr_idx;
            din_q <= din;
            wr_q  <= wr_rd;
            if (LATENCY == 1) begin
              state_q <= S_ACK;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_LOAD;
            end
          end
`ifdef SDRAM_REFRESH_EN
          else if (ref_due_q) begin
            state_q <= S_REFRESH;
            cnt_q   <= REF_LOAD;
          end
`endif
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: state_q <= S_IDLE;
`ifdef SDRAM_REFRESH_EN
        S_REFRESH: begin
          if (cnt_q == 4'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
`endif
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign DOut  = dout_q;
  assign rdy   = rdy_q;
  assign busy  = (state_q != S_IDLE);
  assign ovr   = ovr_q;
  assign state = state_q;

endmodule

// File: tb/tb_sdram_model.sv
// Testbench for sdram_model (default build, refresh disabled).
module tb_sdram_model;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] Address;
  logic        wr_rd;
  logic        mstrb;
  logic [31:0] din;
  logic [31:0] DOut;
  logic        rdy;
  logic        busy;
  logic        ovr;
  logic [2:0]  state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [256];
  logic [31:0] exp_dout;

  always #5 clk = ~clk;

  sdram_model #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst_b), .Address(Address), .wr_rd(wr_rd), .mstrb(mstrb),
    .din(din), .DOut(DOut), .rdy(rdy), .busy(busy), .ovr(ovr), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < 256; i++) model[i] = {4{8'(i)}};
  endfunction

  // Counts rising edges after reset release until busy drops; INIT must take 256 edges
  task automatic wait_init();
    int n = 0;
    int rdy_seen = 0;
    bit nonzero_state = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (rdy) rdy_seen++;
      if (busy && state != 3'd0) nonzero_state = 1'b1;
    end while (busy && n < 400);
    chk("init_len", 32'(n), 32'd256);
    chk("init_state_code", 32'(nonzero_state), 32'd0);
    chk("init_no_rdy", 32'(rdy_seen), 32'd0);
    chk("idle_state", 32'(state), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // One access from IDLE; called and returns at posedge+1
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    int k;
    chk("acc_busy_before", 32'(busy), 32'd0);
    Address = a; wr_rd = w; din = d; mstrb = 1'b1;
    @(posedge clk); #1;
    mstrb = 1'b0; Address = $urandom; din = $urandom; wr_rd = 1'($urandom);
    k = 1;
    while (!rdy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (w) model[a[7:0]] = d;
    else   exp_dout = model[a[7:0]];
    chk("acc_rdy", 32'(rdy), 32'd1);
    chk("acc_latency", 32'(k), 32'(LAT));
    chk("acc_dout", DOut, exp_dout);
    @(posedge clk); #1;
    chk("acc_rdy_pulse", 32'(rdy), 32'd0);
    chk("acc_dout_held", DOut, exp_dout);
  endtask

  initial begin
    int gap;
    int rdy_cnt;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;

    rst_b = 1'b0; Address = '0; wr_rd = 1'b0; mstrb = 1'b0; din = '0;
    exp_dout = '0;
    model_init();
    #12;
    chk("rst_dout", DOut, 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    rst_b = 1'b1;
    wait_init();
    chk("init_ovr", 32'(ovr), 32'd0);

    // Directed: init pattern, write/read, alias
    access(1'b0, 32'h0000_0005, 32'h0);
    chk("read_05", DOut, 32'h0505_0505);
    access(1'b1, 32'h0000_0012, 32'hDEAD_BEEF);
    chk("write_keeps_dout", DOut, 32'h0505_0505);
    access(1'b0, 32'h0000_0012, 32'h0);
    chk("read_12", DOut, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0112, 32'h0);
    chk("read_alias_112", DOut, 32'hDEAD_BEEF);
    access(1'b0, 32'hFFFF_FFFF, 32'h0);
    chk("read_ff", DOut, 32'hFFFF_FFFF);
    chk("no_ovr_yet", 32'(ovr), 32'd0);

    // Randomized accesses over a small index window with random upper bits
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom);
      a = $urandom;
      a[7:0] = 8'($urandom_range(0, 15));
      d = $urandom;
      access(w, a, d);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end

    // Overrun: second strobe two cycles after the first is dropped
    Address = 32'h0000_0031; wr_rd = 1'b0; mstrb = 1'b1;
    @(posedge clk); #1; mstrb = 1'b0;
    @(posedge clk); #1;
    Address = 32'h0000_0040; wr_rd = 1'b1; din = 32'h1234_5678; mstrb = 1'b1;
    @(posedge clk); #1; mstrb = 1'b0;
    @(posedge clk); #1;
    exp_dout = model[8'h31];
    chk("ovr_first_rdy", 32'(rdy), 32'd1);
    chk("ovr_first_dout", DOut, exp_dout);
    rdy_cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (rdy) rdy_cnt++; end
    chk("ovr_second_no_rdy", 32'(rdy_cnt), 32'd0);
    chk("ovr_set", 32'(ovr), 32'd1);
    access(1'b0, 32'h0000_0040, 32'h0);
    chk("ovr_dropped_write", DOut, 32'h4040_4040);
    chk("ovr_sticky", 32'(ovr), 32'd1);

    // Reset during WAIT aborts the access and re-initialises the array
    access(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    Address = 32'h0000_0020; wr_rd = 1'b0; mstrb = 1'b1;
    @(posedge clk); #1; mstrb = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    chk("midrst_dout", DOut, 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_ovr", 32'(ovr), 32'd0);
    rdy_cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (rdy) rdy_cnt++; end
    chk("midrst_no_rdy", 32'(rdy_cnt), 32'd0);
    rst_b = 1'b1;
    model_init();
    exp_dout = '0;
    wait_init();
    access(1'b0, 32'h0000_0020, 32'h0);
    chk("reinit_read_20", DOut, 32'h2020_2020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_model.md
Name: sdram_model

Overview:
Behavioural SDRAM back-end that sits directly downstream of cache_top and services its line fill and write-back word transfers. It consumes the Address_sdram, wr_rd_sdram, mstrb_sdram and din_sdram outputs of cache_top, and returns DOut_sdram plus a one-cycle completion pulse. The read/write latency is programmable. After reset the block self-initialises its array with a known pattern, so ChipScope captures are deterministic.

Parameters:
ADDR_W, 8, word-index width; array depth = 2^ADDR_W words
DATA_W, 32, data word width (DATA_W must be a multiple of 8)
LATENCY, 4, rising edges from the strobe sample to rdy; legal range 1..15
REFRESH_PERIOD, 64, cycles between refresh requests (only with SDRAM_REFRESH_EN)
REFRESH_CYCLES, 3, stall length of one refresh (only with SDRAM_REFRESH_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
Address  input  32  access address; word index = Address[ADDR_W-1:0], upper bits ignored
wr_rd  input  1  1 = write, 0 = read; sampled together with mstrb
mstrb  input  1  single-cycle access strobe
din  input  DATA_W  write data; sampled together with mstrb
DOut  output  DATA_W  read data; updated only when a read completes, held otherwise
rdy  output  1  one-cycle pulse marking access completion
busy  output  1  high when a strobe would not be accepted (any state other than IDLE)
ovr  output  1  sticky flag: a strobe was dropped; cleared only by reset
state  output  3  FSM state code, for ILA/LED debug

Behaviour:
- Reset (rst=0, asynchronous):
  - DOut=0, rdy=0, ovr=0, busy=1.
  - state=INIT, init index=0, latency counter=0, captured registers=0.
  - The array itself is not reset; INIT rewrites it.
- State codes: INIT=0, IDLE=1, WAIT=2, ACK=3, REFRESH=4.
- INIT:
  - Writes one word per cycle: mem[i] = byte (i mod 256) replicated across DATA_W (e.g. mem[0x05]=0x05050505).
  - Runs for 2^ADDR_W cycles; after writing the last index, moves to IDLE.
  - busy=1 throughout.
- IDLE:
  - busy=0.
  - If mstrb=1: capture Address index, din and wr_rd; go to ACK if LATENCY=1, else go to WAIT with counter=LATENCY-2.
- WAIT:
  - Decrement the counter each cycle; move to ACK on the cycle after the counter reads 0.
- ACK:
  - rdy=1 for exactly this cycle.
  - Write: mem[idx]<=din_q on the edge entering ACK.
  - Read: DOut<=mem[idx] on the edge entering ACK, so DOut is valid in the same cycle as rdy.
  - Always returns to IDLE next cycle.
- Latency: the strobe is sampled at edge E; rdy is high during the cycle following edge E+LATENCY-1, i.e. rdy rises LATENCY edges after the sampling edge, counting E as the first.
- Dropped strobes: mstrb=1 in INIT, WAIT, ACK or REFRESH is ignored and sets ovr=1. There is no queueing; cache_top must respect busy/rdy.
- Read after write to the same index returns the new data. Address bits above ADDR_W alias onto the same word.
- rst asserted mid-access: the access is aborted, no rdy, any pending write is lost, and the array is re-initialised through INIT.
- DOut is never driven by writes or by INIT.

Optional Feature:
- Macro SDRAM_REFRESH_EN.
- Defined:
  - A free-running counter starts on INIT exit and sets refresh_due on reaching REFRESH_PERIOD-1, then wraps to 0.
  - In IDLE with refresh_due=1 and mstrb=0: enter REFRESH for REFRESH_CYCLES cycles (busy=1), clear refresh_due, then return to IDLE.
  - If mstrb=1 in the same IDLE cycle, the access wins and refresh is deferred to the next IDLE cycle.
  - Strobes during REFRESH set ovr.
- Undefined: no REFRESH state, no refresh counter logic; state code 4 never appears.

Test Plan:
1. Release rst at cycle 0 -> busy=1 for 256 cycles, state=0, then state=1 and busy=0; ovr=0.
2. Read after init: Address=0x00000005, wr_rd=0, mstrb pulse -> rdy pulses 4 edges later; DOut=0x05050505 while rdy=1 and held afterwards.
3. Write then read: write din=0xDEADBEEF to Address=0x12 -> rdy after 4 edges, DOut unchanged. Read 0x12 -> DOut=0xDEADBEEF. Read 0x112 -> 0xDEADBEEF (alias).
4. Overrun: strobe at IDLE, second strobe 2 cycles later -> the first completes normally, the second produces no rdy, ovr=1 and stays 1.
5. Reset mid-WAIT: after writing 0xCAFEF00D to 0x20, start a read, pull rst low one cycle later -> no rdy, DOut=0, INIT reruns, and a later read of 0x20 returns 0x20202020.
6. With SDRAM_REFRESH_EN and PERIOD=64, CYCLES=3: idle run -> state=4 for 3 cycles every 64. A strobe coinciding with refresh_due is served first, then REFRESH follows.
